// File: rtl/gate_sweep_ctrl_if.sv
// Purpose: bundles the sweep controller's request, gate-drive and result
// signals into one interface.
//   slave  : the controller side (gate_sweep_ctrl)
//   master : the requester/gate side (bench or self-test wrapper)
// Signals:
//   start      master->slave  one-cycle sweep request
//   w_in       master->slave  output of the gate under test
//   abcd       slave->master  gate input vector {a,b,c,d}
//   busy       slave->master  sweep in progress
//   done       slave->master  one-cycle completion pulse
//   err_count  slave->master  number of mismatching vectors
//   fail_seen  slave->master  at least one mismatch seen
//   first_fail slave->master  index of first mismatching vector
//   pass       slave->master  sweep finished with no mismatch (DONE pulse only)
interface gate_sweep_ctrl_if;
  logic       start;
  logic       w_in;
  logic [3:0] abcd;
  logic       busy;
  logic       done;
  logic [4:0] err_count;
  logic       fail_seen;
  logic [3:0] first_fail;
  logic       pass;

  modport slave (
    input  start,
    input  w_in,
    output abcd,
    output busy,
    output done,
    output err_count,
    output fail_seen,
    output first_fail,
    output pass
  );

  modport master (
    output start,
    output w_in,
    input  abcd,
    input  busy,
    input  done,
    input  err_count,
    input  fail_seen,
    input  first_fail,
    input  pass
  );
endinterface

// File: rtl/gate_sweep_ctrl.sv
// Purpose: sequencer/checker for the CMOS gate w = (~c&~d) | (d&~(a&b)).
// Walks all 16 vectors {a,b,c,d} in ascending order, holds each for
// SETTLE_CYCLES clocks so the transistor-level delays can settle, samples w,
// and accumulates mismatch count plus the index of the first failing vector.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : gate_sweep_ctrl_if.slave (start, w_in in; abcd, busy, done,
//          err_count, fail_seen, first_fail, pass out, all registered)
module gate_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  gate_sweep_ctrl_if.slave  bus
);

  localparam int unsigned VEC_W = 4;
  localparam int unsigned ERR_W = 5;
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(15);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_W-1:0]   abcd_q, abcd_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fail_seen_q, fail_seen_d;
  logic [VEC_W-1:0]   first_fail_q, first_fail_d;
  logic               mismatch_c;

  // Reference function of the gate under test.
  function automatic logic golden(input logic [VEC_W-1:0] v);
    logic a, b, c, d;
    a = v[3];
    b = v[2];
    c = v[1];
    d = v[0];
    return (~c & ~d) | (d & ~(a & b));
  endfunction

  // Case inequality so an X/Z on w_in is scored as a failure.
  assign mismatch_c = (bus.w_in !== golden(vec_q));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      cnt_q        <= '0;
      abcd_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_seen_q  <= 1'b0;
      first_fail_q <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      cnt_q        <= cnt_d;
      abcd_q       <= abcd_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_q        <= err_d;
      fail_seen_q  <= fail_seen_d;
      first_fail_q <= first_fail_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    cnt_d        = cnt_q;
    abcd_d       = abcd_q;
    done_d       = 1'b0;
    pass_d       = 1'b0;
    err_d        = err_q;
    fail_seen_d  = fail_seen_q;
    first_fail_d = first_fail_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d      = SETTLE;
          vec_d        = '0;
          abcd_d       = '0;
          cnt_d        = '0;
          err_d        = '0;
          fail_seen_d  = 1'b0;
          first_fail_d = '0;
        end
      end

      SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        // At most 16 increments, so err_q cannot wrap.
        if (mismatch_c) begin
          err_d = err_q + ERR_W'(1);
          if (!fail_seen_q) begin
            fail_seen_d  = 1'b1;
            first_fail_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          state_d = SETTLE;
          vec_d   = vec_q + VEC_W'(1);
          abcd_d  = vec_q + VEC_W'(1);
          cnt_d   = '0;
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        pass_d  = (err_q == '0);
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == CHECK);
  end

  assign bus.abcd       = abcd_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = fail_seen_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: a delayed gate model (or faulty stand-ins)
// feeds w_in; expected sweep results are queued at start and compared at done.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_r = 1'b0;
  int   sel = 0;
  int   mode = 0;
  logic xv = 1'bx;
  logic [15:0] gold_tbl = 16'h1BBB;
  logic w_gate0 = 1'b1;
  logic w_drv0;

  int total = 0;
  int bad = 0;

  gate_sweep_ctrl_if bus0 ();
  gate_sweep_ctrl_if bus1 ();

  gate_sweep_ctrl #(.SETTLE_CYCLES(4), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  gate_sweep_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // Gate model for dut0: output follows the inputs after 27 ns.
  always @(bus0.abcd) w_gate0 <= #27 gold_tbl[bus0.abcd];

  // Fault modes: 0 correct gate, 1 stuck at 1, 2 X on vector 5.
  always @* begin
    case (mode)
      1:       w_drv0 = 1'b1;
      2:       w_drv0 = (bus0.abcd == 4'd5) ? xv : w_gate0;
      default: w_drv0 = w_gate0;
    endcase
  end

  assign bus0.w_in  = w_drv0;
  assign bus1.w_in  = gold_tbl[bus1.abcd];
  assign bus0.start = (sel == 0) ? start_r : 1'b0;
  assign bus1.start = (sel == 1) ? start_r : 1'b0;

  logic [3:0] s_abcd, s_ff;
  logic [4:0] s_err;
  logic       s_busy, s_done, s_fs, s_pass;
  assign s_abcd = (sel == 0) ? bus0.abcd       : bus1.abcd;
  assign s_ff   = (sel == 0) ? bus0.first_fail : bus1.first_fail;
  assign s_err  = (sel == 0) ? bus0.err_count  : bus1.err_count;
  assign s_busy = (sel == 0) ? bus0.busy       : bus1.busy;
  assign s_done = (sel == 0) ? bus0.done       : bus1.done;
  assign s_fs   = (sel == 0) ? bus0.fail_seen  : bus1.fail_seen;
  assign s_pass = (sel == 0) ? bus0.pass       : bus1.pass;

  typedef struct {
    int mode;
    int err;
    int fs;
    int ff;
    int pass;
  } vec_t;

  typedef struct {
    int err;
    int fs;
    int ff;
    int pass;
    int lat;
  } exp_t;

  vec_t tbl[4];
  exp_t sb_q[$];

  int act_err, act_fs, act_ff, act_pass, act_lat;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Follows one sweep from the accepting edge (n=0); checks vector order and
  // busy each cycle, and captures results when done shows up.
  task automatic watch(input int s, output int lat, output int seq_bad);
    int ev;
    int eb;
    lat = -1;
    seq_bad = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (n <= 16 * (s + 1)) begin
        ev = n / (s + 1);
        if (ev > 15) ev = 15;
        eb = (n < 16 * (s + 1)) ? 1 : 0;
        if (int'(s_abcd) != ev || int'(s_busy) != eb) seq_bad++;
      end
      if (s_done) begin
        lat      = n;
        act_err  = int'(s_err);
        act_fs   = int'(s_fs);
        act_ff   = int'(s_ff);
        act_pass = int'(s_pass);
        break;
      end
    end
    act_lat = lat;
  endtask

  task automatic run_sweep(input int s, input bit hold, output int lat, output int seq_bad);
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_r = 1'b0;
    watch(s, lat, seq_bad);
  endtask

  task automatic score(input string nm);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk({nm, "_queue_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_latency"}, act_lat, e.lat);
      chk({nm, "_err_count"}, act_err, e.err);
      chk({nm, "_fail_seen"}, act_fs, e.fs);
      chk({nm, "_first_fail"}, act_ff, e.ff);
      chk({nm, "_pass"}, act_pass, e.pass);
    end
  endtask

  initial begin
    int lat;
    int sqb;
    int xerr;
    int found;
    int dc;
    exp_t e;

    xerr = (xv !== 1'b1) ? 1 : 0;
    tbl[0] = '{mode: 0, err: 0,    fs: 0,    ff: 0,            pass: 1};
    tbl[1] = '{mode: 1, err: 6,    fs: 1,    ff: 2,            pass: 0};
    tbl[2] = '{mode: 2, err: xerr, fs: xerr, ff: xerr * 5,     pass: 1 - xerr};
    tbl[3] = '{mode: 0, err: 0,    fs: 0,    ff: 0,            pass: 1};

    // Reset values on both instances.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      sel = k;
      #0;
      chk($sformatf("rst%0d_abcd", k), int'(s_abcd), 0);
      chk($sformatf("rst%0d_busy", k), int'(s_busy), 0);
      chk($sformatf("rst%0d_done", k), int'(s_done), 0);
      chk($sformatf("rst%0d_err", k), int'(s_err), 0);
      chk($sformatf("rst%0d_fs", k), int'(s_fs), 0);
      chk($sformatf("rst%0d_ff", k), int'(s_ff), 0);
      chk($sformatf("rst%0d_pass", k), int'(s_pass), 0);
    end
    sel = 0;
    rst = 1'b0;

    // Table of gate behaviours, one full sweep each.
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      e = '{err: tbl[i].err, fs: tbl[i].fs, ff: tbl[i].ff, pass: tbl[i].pass, lat: 81};
      sb_q.push_back(e);
      run_sweep(4, 1'b0, lat, sqb);
      chk($sformatf("row%0d_sequence", i), sqb, 0);
      score($sformatf("row%0d", i));
      @(negedge clk);
      chk($sformatf("row%0d_done_width", i), int'(s_done), 0);
      repeat (3) @(negedge clk);
      chk($sformatf("row%0d_err_hold", i), int'(s_err), tbl[i].err);
      chk($sformatf("row%0d_fs_hold", i), int'(s_fs), tbl[i].fs);
      chk($sformatf("row%0d_busy_idle", i), int'(s_busy), 0);
    end

    // start held high: back-to-back sweeps, one done each.
    mode = 0;
    e = '{err: 0, fs: 0, ff: 0, pass: 1, lat: 81};
    sb_q.push_back(e);
    sb_q.push_back(e);
    run_sweep(4, 1'b1, lat, sqb);
    chk("hold1_sequence", sqb, 0);
    score("hold1");
    watch(4, lat, sqb);
    start_r = 1'b0;
    chk("hold2_sequence", sqb, 0);
    score("hold2");
    repeat (3) @(negedge clk);
    chk("hold_end_busy", int'(s_busy), 0);
    chk("hold_end_done", int'(s_done), 0);

    // Reset mid-sweep while abcd=7 with a stuck-at-1 gate.
    mode = 1;
    @(negedge clk);
    start_r = 1'b1;
    @(posedge clk);
    #1 start_r = 1'b0;
    found = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (s_abcd == 4'd7) begin
        found = 1;
        break;
      end
    end
    chk("abort_reached_vec7", found, 1);
    chk("abort_err_before", int'(s_err), 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_abcd", int'(s_abcd), 0);
    chk("abort_busy", int'(s_busy), 0);
    chk("abort_err", int'(s_err), 0);
    chk("abort_fs", int'(s_fs), 0);
    chk("abort_pass", int'(s_pass), 0);
    dc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_done) dc++;
    end
    chk("abort_no_done", dc, 0);
    mode = 0;
    e = '{err: 0, fs: 0, ff: 0, pass: 1, lat: 81};
    sb_q.push_back(e);
    run_sweep(4, 1'b0, lat, sqb);
    chk("after_abort_sequence", sqb, 0);
    score("after_abort");

    // Minimum settle time on the second instance with a zero-delay gate.
    sel = 1;
    e = '{err: 0, fs: 0, ff: 0, pass: 1, lat: 33};
    sb_q.push_back(e);
    run_sweep(1, 1'b0, lat, sqb);
    chk("settle1_sequence", sqb, 0);
    score("settle1");

    chk("queue_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
